// File: rtl/ahbl_to_apb_if.sv
// Bus bundles for the AHB-lite to APB3 bridge.
//   ahbl_if : AHB-lite slave port as seen from a downstream splitter port.
//             master modport drives address/control/write data and the bus-wide
//             hready; slave modport returns hready_resp, hresp and hrdata.
//   apb_if  : APB3 requester/completer bundle. master modport drives
//             paddr/psel/penable/pwrite/pwdata; slave returns pready/prdata/pslverr.

interface ahbl_if #(
    parameter int unsigned W_HADDR = 32,
    parameter int unsigned W_DATA  = 32
);
    logic                hready;
    logic                hready_resp;
    logic                hresp;
    logic [W_HADDR-1:0]  haddr;
    logic                hwrite;
    logic [1:0]          htrans;
    logic [2:0]          hsize;
    logic [W_DATA-1:0]   hwdata;
    logic [W_DATA-1:0]   hrdata;

    modport master (
        output hready, haddr, hwrite, htrans, hsize, hwdata,
        input  hready_resp, hresp, hrdata
    );

    modport slave (
        input  hready, haddr, hwrite, htrans, hsize, hwdata,
        output hready_resp, hresp, hrdata
    );
endinterface

interface apb_if #(
    parameter int unsigned W_PADDR = 16,
    parameter int unsigned W_DATA  = 32
);
    logic [W_PADDR-1:0]  paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [W_DATA-1:0]   pwdata;
    logic                pready;
    logic [W_DATA-1:0]   prdata;
    logic                pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/ahbl_to_apb.sv
// AHB-lite slave to APB3 master bridge. Each accepted AHB-lite transfer becomes
// one APB3 transfer; all AHB-side responses come from flops so nothing on the
// APB side reaches hready_resp/hresp/hrdata combinationally.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   ahbls    : AHB-lite slave port (ahbl_if.slave)
//   apbm     : APB3 master port (apb_if.master); pwdata is a straight wire from hwdata

module ahbl_to_apb #(
    parameter int unsigned W_HADDR = 32,
    parameter int unsigned W_PADDR = 16,
    parameter int unsigned W_DATA  = 32
) (
    input  logic   clk,
    input  logic   rst,
    ahbl_if.slave  ahbls,
    apb_if.master  apbm
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_ERR0   = 3'd4,
        S_ERR1   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic                hready_resp_q, hready_resp_d;
    logic                hresp_q, hresp_d;
    logic [W_PADDR-1:0]  paddr_q, paddr_d;
    logic [W_DATA-1:0]   hrdata_q, hrdata_d;
    logic                accept_c;
    logic                unused_ok;

    // hsize, htrans[0] and the upper address bits carry no meaning for a full-word APB3 port
    assign unused_ok = ^{ahbls.hsize, ahbls.htrans[0], ahbls.haddr[W_HADDR-1:W_PADDR]};

    // New address phase: NONSEQ/SEQ while the bridge is in a state that can take one
    assign accept_c = ahbls.hready && ahbls.htrans[1] &&
                      (state_q == S_IDLE || state_q == S_RESP || state_q == S_ERR1);

    // Next state, captured address/data, and the registered outputs decoded from the next state
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        hrdata_d = hrdata_q;

        case (state_q)
            S_IDLE, S_RESP, S_ERR1: state_d = accept_c ? S_SETUP : S_IDLE;
            S_SETUP:                state_d = S_ACCESS;
            S_ACCESS: begin
                // pslverr only counts on the completing ACCESS cycle
                if (apbm.pready) begin
                    if (!pwrite_q) begin
                        hrdata_d = apbm.prdata;
                    end
                    state_d = apbm.pslverr ? S_ERR0 : S_RESP;
                end
            end
            S_ERR0:                 state_d = S_ERR1;
            default:                state_d = S_IDLE;
        endcase

        if (accept_c) begin
            paddr_d  = ahbls.haddr[W_PADDR-1:0];
            pwrite_d = ahbls.hwrite;
        end

        psel_d        = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d     = (state_d == S_ACCESS);
        hready_resp_d = !((state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_ERR0));
        hresp_d       = (state_d == S_ERR0) || (state_d == S_ERR1);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            hrdata_q      <= '0;
            hready_resp_q <= 1'b1;
            hresp_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            hrdata_q      <= hrdata_d;
            hready_resp_q <= hready_resp_d;
            hresp_q       <= hresp_d;
        end
    end

    assign apbm.paddr        = paddr_q;
    assign apbm.psel         = psel_q;
    assign apbm.penable      = penable_q;
    assign apbm.pwrite       = pwrite_q;
    assign apbm.pwdata       = ahbls.hwdata;
    assign ahbls.hready_resp = hready_resp_q;
    assign ahbls.hresp       = hresp_q;
    assign ahbls.hrdata      = hrdata_q;

endmodule
